fifo_write_arbiter: RTL
=======================

# fifo_write_arbiter

Round-robin burst arbiter that shares the single write port of the dual-port FIFO controller among several producers in the write-clock domain. Each producer requests a burst of N words. The arbiter grants one producer at a time and streams its words into the FIFO, throttling on the FIFO full flag. It sits between the producer blocks (sprite/tile fetchers) and the FIFO write side.

## Interface
Parameters:
- pReqNum, 4, number of requesters (2..8)
- pBitWidth, 24, data word width; must match the FIFO bit width
- pLenWidth, 8, burst length field width; a burst is iLen+1 words (1..2^pLenWidth)

Ports:
- iClk  in  1  write-side clock, same clock as the FIFO write port
- iRst  in  1  asynchronous, active-low reset
- iReq  in  pReqNum  per-requester burst request; level, held until oDone
- iLen  in  pReqNum*pLenWidth  per-requester burst length minus one; slice k = bits [k*pLenWidth +: pLenWidth]
- iWD  in  pReqNum*pBitWidth  per-requester write data; slice k as above
- oGnt  out  pReqNum  one-hot grant, registered
- oAck  out  pReqNum  word accepted from requester k this cycle; combinational
- oDone  out  pReqNum  one-cycle pulse, burst of requester k complete, registered
- oFifoWD  out  pBitWidth  FIFO write data, registered
- oFifoWE  out  1  FIFO write enable, registered
- iFifoFull  in  1  FIFO full flag; asserts with at least 6 free entries

## Operation
- Reset values:
  - FSM in IDLE.
  - oGnt, oAck, oDone, oFifoWE and oFifoWD are all 0.
  - Round-robin pointer rLast = pReqNum-1, so requester 0 has first priority.
  - Word counter = 0.
- States: IDLE, BURST, DONE.
- IDLE:
  - If iReq is nonzero, select the first asserted requester searching from (rLast+1) mod pReqNum upward with wrap.
  - Register the index g, load counter = iLen[g], set oGnt[g], and go to BURST.
  - If iReq is zero, stay in IDLE.
- BURST:
  - Transfer condition: qXfer = ~iFifoFull.
  - When qXfer: oAck[g] = 1, the arbiter captures iWD[g] into oFifoWD and sets oFifoWE = 1 on the next edge, and the counter decrements.
  - When ~qXfer: oAck = 0 and oFifoWE = 0 next cycle.
  - When qXfer with counter == 0, this is the last word: go to DONE, clear oGnt, and set rLast = g.
- DONE:
  - oDone[g] = 1 for exactly one cycle, then go to IDLE.
  - oFifoWE carries the last word during this cycle.
- Requester protocol:
  - Present word 0 on iWD[k] while oGnt[k] is high.
  - Advance to the next word on the edge after each oAck[k].
  - Hold iReq until oDone[k], then deassert it for at least 1 cycle before re-requesting.
- iReq[g] deasserting mid-burst is ignored: the burst runs to completion.
- iLen and iReq changes on non-granted requesters have no effect until the next IDLE arbitration.
- oAck is never asserted for a non-granted requester. oGnt and oAck are always one-hot or zero.

## Timing
- Request to first FIFO write:
  - iReq sampled in IDLE at edge T.
  - oGnt and BURST from T+1.
  - First oAck in cycle T+1 if not full.
  - First oFifoWE in cycle T+2.
- Throughput: 1 word/cycle while iFifoFull = 0.
- Per-burst overhead is 2 cycles (IDLE + DONE) between the last oAck of one burst and the first oAck of the next.
- Full throttling:
  - iFifoFull is used combinationally in BURST.
  - oFifoWE lags oAck by exactly 1 cycle, so at most 1 word is written after full asserts; the 6-entry margin of the full flag covers this.
- Full held indefinitely: the arbiter stalls in BURST with oGnt held. There is no timeout.
- Reset mid-burst: all outputs drop to 0 asynchronously. The partial burst is abandoned and no oDone is issued.
- Counter and length are pLenWidth bits. iLen = all-ones gives 2^pLenWidth words with no overflow.

## Test plan
- Single burst, with reset released and the FIFO never full:
  - Stimulus: iReq[1] = 1, iLen[1] = 3.
  - Required response: oGnt[1] rises the cycle after the request; 4 consecutive oAck[1]; oFifoWE high for 4 cycles carrying words D0..D3 in order; oDone[1] pulses once, 1 cycle after the last oAck; oGnt returns to 0.
- Round-robin fairness:
  - Stimulus: iReq = 4'b1111 continuously, all iLen = 0.
  - Required response: grant order 0,1,2,3,0,1, with 1 word per grant and 3 cycles per grant.
- Full throttling:
  - Stimulus: iLen[0] = 7; drive iFifoFull = 1 for 5 cycles after the 3rd oAck.
  - Required response: no oAck during those 5 cycles; oFifoWE low from the cycle after full asserts; all 8 words written in order; exactly 8 oFifoWE pulses.
- Priority after reset:
  - Stimulus: iReq = 4'b1010 asserted simultaneously, immediately after reset.
  - Required response: requester 1 is granted first, then requester 3.
- Reset mid-burst:
  - Stimulus: iLen[2] = 15; pull iRst low after the 5th oAck.
  - Required response: oGnt, oFifoWE and oDone are 0 immediately; after release with iReq = 4'b0101, requester 0 is granted first.
- Maximum length:
  - Stimulus: iLen[3] = 8'hFF, FIFO never full.
  - Required response: exactly 256 oFifoWE pulses, then oDone[3].

Source files
------------

// File: rtl/fifo_write_arbiter_if.sv
// Producer-side and FIFO-side signals of the write-port arbiter.
// The arbiter uses the master view. Producers and the FIFO use the slave view.
interface fifo_write_arbiter_if #(
    parameter int pReqNum   = 4,
    parameter int pBitWidth = 24,
    parameter int pLenWidth = 8
);
    logic [pReqNum-1:0]           iReq;
    logic [pReqNum*pLenWidth-1:0] iLen;
    logic [pReqNum*pBitWidth-1:0] iWD;
    logic [pReqNum-1:0]           oGnt;
    logic [pReqNum-1:0]           oAck;
    logic [pReqNum-1:0]           oDone;
    logic [pBitWidth-1:0]         oFifoWD;
    logic                         oFifoWE;
    logic                         iFifoFull;

    modport master (
        input  iReq, iLen, iWD, iFifoFull,
        output oGnt, oAck, oDone, oFifoWD, oFifoWE
    );

    modport slave (
        output iReq, iLen, iWD, iFifoFull,
        input  oGnt, oAck, oDone, oFifoWD, oFifoWE
    );
endinterface

// File: rtl/fifo_write_arbiter.sv
// Round-robin burst arbiter that shares the FIFO write port among several producers.
// It grants one producer at a time and streams its burst into the FIFO, stalling while the FIFO is full.
module fifo_write_arbiter #(
    parameter int pReqNum   = 4,
    parameter int pBitWidth = 24,
    parameter int pLenWidth = 8
) (
    input logic                  iClk,
    input logic                  iRst,
    fifo_write_arbiter_if.master bus
);
    localparam int cIdxW = (pReqNum > 1) ? $clog2(pReqNum) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_BURST = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic [cIdxW-1:0]   cLastInit = cIdxW'(pReqNum - 1);
    localparam logic [pReqNum-1:0] cOneHot0  = {{(pReqNum-1){1'b0}}, 1'b1};

    logic [1:0]           r_state;
    logic [cIdxW-1:0]     r_gntIdx;
    logic [cIdxW-1:0]     r_last;
    logic [pLenWidth-1:0] r_cnt;
    logic [pReqNum-1:0]   r_gnt;
    logic [pReqNum-1:0]   r_done;
    logic [pBitWidth-1:0] r_fifoWD;
    logic                 r_fifoWE;

    logic [pLenWidth-1:0] w_lenArr [pReqNum];
    logic [pBitWidth-1:0] w_wdArr  [pReqNum];
    logic [cIdxW-1:0]     w_sel;
    logic [cIdxW-1:0]     w_cand;
    logic                 w_xfer;

    for (genvar k = 0; k < pReqNum; k++) begin : g_slice
        assign w_lenArr[k] = bus.iLen[k*pLenWidth +: pLenWidth];
        assign w_wdArr[k]  = bus.iWD[k*pBitWidth +: pBitWidth];
    end

    // Scan from farthest to nearest after r_last so that the nearest asserted requester is selected.
    always_comb begin
        w_sel  = r_last;
        w_cand = r_last;
        for (int i = pReqNum; i >= 1; i--) begin
            w_cand = cIdxW'((int'(r_last) + i) % pReqNum);
            if (bus.iReq[w_cand]) begin
                w_sel = w_cand;
            end
        end
    end

    assign w_xfer = ~bus.iFifoFull;

    assign bus.oAck    = ((r_state == S_BURST) && w_xfer) ? r_gnt : '0;
    assign bus.oGnt    = r_gnt;
    assign bus.oDone   = r_done;
    assign bus.oFifoWD = r_fifoWD;
    assign bus.oFifoWE = r_fifoWE;

    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            r_state  <= S_IDLE;
            r_gntIdx <= '0;
            r_last   <= cLastInit;
            r_cnt    <= '0;
            r_gnt    <= '0;
            r_done   <= '0;
            r_fifoWD <= '0;
            r_fifoWE <= 1'b0;
        end else begin
            r_done   <= '0;
            r_fifoWE <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (|bus.iReq) begin
                        r_gntIdx <= w_sel;
                        r_cnt    <= w_lenArr[w_sel];
                        r_gnt    <= cOneHot0 << w_sel;
                        r_state  <= S_BURST;
                    end
                end
                S_BURST: begin
                    if (w_xfer) begin
                        r_fifoWD <= w_wdArr[r_gntIdx];
                        r_fifoWE <= 1'b1;
                        r_cnt    <= r_cnt - 1'b1;
                        // A zero count means this is the last word, so the counter never has to reach 2^pLenWidth.
                        if (r_cnt == '0) begin
                            r_state <= S_DONE;
                            r_gnt   <= '0;
                            r_done  <= r_gnt;
                            r_last  <= r_gntIdx;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end
endmodule
